// File: rtl/tmr_mismatch_monitor_if.sv
// Mismatch-flag bundle and statistics outputs of the TMR mismatch monitor.
// The master drives flags and clear requests; the monitor is the slave.
interface tmr_mismatch_monitor_if #(
    parameter int N_INPUTS  = 8,
    parameter int CNT_WIDTH = 16,
    parameter int IDX_W     = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
);
    logic [N_INPUTS-1:0]  mismatch_i;
    logic                 clear_req_i;
    logic                 clear_ack_o;
    logic [CNT_WIDTH-1:0] event_count_o;
    logic [N_INPUTS-1:0]  sticky_o;
    logic [IDX_W-1:0]     first_idx_o;
    logic                 first_valid_o;
    logic [N_INPUTS-1:0]  persistent_o;
    logic                 irq_o;

    modport master (
        output mismatch_i, clear_req_i,
        input  clear_ack_o, event_count_o, sticky_o, first_idx_o,
               first_valid_o, persistent_o, irq_o
    );

    modport slave (
        input  mismatch_i, clear_req_i,
        output clear_ack_o, event_count_o, sticky_o, first_idx_o,
               first_valid_o, persistent_o, irq_o
    );
endinterface

// File: rtl/tmr_mismatch_monitor.sv
// SEU statistics for TMR voter mismatch flags: saturating event count, sticky
// flags, first-fault index, persistent-fault detection and req/ack clear.
module tmr_mismatch_monitor #(
    parameter int N_INPUTS       = 8,
    parameter int CNT_WIDTH      = 16,
    parameter int PERSIST_CYCLES = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    tmr_mismatch_monitor_if.slave bus
);
    localparam int IDX_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam int SUM_W = CNT_WIDTH + 7;
    localparam logic [SUM_W-1:0] CNT_MAX = {{7{1'b0}}, {CNT_WIDTH{1'b1}}};
    localparam logic [7:0] PERSIST = 8'(PERSIST_CYCLES);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_ACK  = 1'b1;

    logic [0:0]                 state;
    logic [N_INPUTS-1:0]        mm_q, mm_qq, rise;
    logic [CNT_WIDTH-1:0]       cnt, cnt_nxt;
    logic [N_INPUTS-1:0]        sticky, pers, pers_nxt;
    logic [IDX_W-1:0]           fidx, low_idx;
    logic                       fvalid, irq;
    logic [N_INPUTS-1:0][7:0]   run, run_nxt;
    logic [6:0]                 rise_cnt;
    logic [SUM_W-1:0]           sum;
    logic                       clear_fire;

    assign rise       = mm_q & ~mm_qq;
    assign clear_fire = (state == S_IDLE) && bus.clear_req_i;

    always_comb begin
        rise_cnt = '0;
        for (int i = 0; i < N_INPUTS; i++)
            rise_cnt = rise_cnt + 7'(rise[i]);
    end

    // Sum is wide enough that adding a full popcount can never wrap.
    always_comb begin
        sum     = SUM_W'(cnt) + SUM_W'(rise_cnt);
        cnt_nxt = (sum > CNT_MAX) ? {CNT_WIDTH{1'b1}} : sum[CNT_WIDTH-1:0];
    end

    always_comb begin
        low_idx = '0;
        for (int i = N_INPUTS - 1; i >= 0; i--)
            if (rise[i]) low_idx = IDX_W'(i);
    end

    // Per-input run counter of consecutive asserted cycles.
    for (genvar g = 0; g < N_INPUTS; g++) begin : g_lane
        always_comb begin
            if (!mm_q[g])             run_nxt[g] = '0;
            else if (run[g] == PERSIST) run_nxt[g] = PERSIST;
            else                      run_nxt[g] = run[g] + 8'd1;
            pers_nxt[g] = pers[g] | (run_nxt[g] == PERSIST);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state  <= S_IDLE;
            mm_q   <= '0;
            mm_qq  <= '0;
            cnt    <= '0;
            sticky <= '0;
            fidx   <= '0;
            fvalid <= 1'b0;
            pers   <= '0;
            run    <= '0;
            irq    <= 1'b0;
        end else begin
            mm_q  <= bus.mismatch_i;
            mm_qq <= mm_q;

            case (state)
                S_IDLE:  if (bus.clear_req_i)  state <= S_ACK;
                default: if (!bus.clear_req_i) state <= S_IDLE;
            endcase

            // The clearing edge discards whatever rise/mm_q it sees.
            if (clear_fire) begin
                cnt    <= '0;
                sticky <= '0;
                fidx   <= '0;
                fvalid <= 1'b0;
                pers   <= '0;
                run    <= '0;
                irq    <= 1'b0;
            end else begin
                cnt    <= cnt_nxt;
                sticky <= sticky | mm_q;
                if (!fvalid && (|rise)) begin
                    fidx   <= low_idx;
                    fvalid <= 1'b1;
                end
                pers <= pers_nxt;
                run  <= run_nxt;
                irq  <= ((cnt == '0) && (cnt_nxt != '0)) || (|(pers_nxt & ~pers));
            end
        end
    end

    assign bus.clear_ack_o   = (state == S_ACK);
    assign bus.event_count_o = cnt;
    assign bus.sticky_o      = sticky;
    assign bus.first_idx_o   = fidx;
    assign bus.first_valid_o = fvalid;
    assign bus.persistent_o  = pers;
    assign bus.irq_o         = irq;
endmodule

// File: tb/tb_tmr_mismatch_monitor.sv
// Directed scenarios with literal expectations plus a randomized phase, all
// compared every cycle against a history-based model of the statistics rules.
module tb_tmr_mismatch_monitor;
    localparam int N    = 8;
    localparam int CW   = 4;
    localparam int P    = 16;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_assert = 0;
    int   n_fail = 0;

    tmr_mismatch_monitor_if #(.N_INPUTS(N), .CNT_WIDTH(CW)) bus ();

    tmr_mismatch_monitor #(.N_INPUTS(N), .CNT_WIDTH(CW), .PERSIST_CYCLES(P)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    // History since the last reset: hist[e]/rq[e] are inputs sampled at edge e.
    logic [N-1:0] hist [0:4095];
    bit           rq   [0:4095];
    int           n = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n <= 0;
        end else begin
            n          <= n + 1;
            hist[n+1]  <= bus.mismatch_i;
            rq[n+1]    <= bus.clear_req_i;
        end
    end

    typedef struct {
        int           cnt;
        logic [N-1:0] st;
        int           fidx;
        bit           fv;
        logic [N-1:0] pers;
        bit           ack;
    } exp_t;

    function automatic logic [N-1:0] h_at(int e);
        return (e < 1) ? '0 : hist[e];
    endfunction

    // Expected statistics after edge k, replayed from the last clear edge.
    function automatic exp_t model(int k);
        exp_t e;
        int   c, sum;
        int   runlen [N];
        e.cnt = 0; e.st = '0; e.fidx = 0; e.fv = 1'b0; e.pers = '0; e.ack = 1'b0;
        if (k == 0) return e;
        e.ack = rq[k];
        c = 0;
        for (int m = k; m >= 1; m--)
            if (rq[m] && (m == 1 || !rq[m-1])) begin c = m; break; end
        sum = 0;
        for (int i = 0; i < N; i++) runlen[i] = 0;
        for (int m = c + 1; m <= k; m++) begin
            logic [N-1:0] q, rs;
            q  = h_at(m - 1);
            rs = q & ~h_at(m - 2);
            sum += $countones(rs);
            if (!e.fv && rs != 0) begin
                e.fv = 1'b1;
                for (int i = N - 1; i >= 0; i--) if (rs[i]) e.fidx = i;
            end
            e.st |= q;
            for (int i = 0; i < N; i++) begin
                runlen[i] = q[i] ? runlen[i] + 1 : 0;
                if (runlen[i] >= P) e.pers[i] = 1'b1;
            end
        end
        e.cnt = (sum > CMAX) ? CMAX : sum;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e, ep;
        bit   irq_e;
        e = model(n);
        irq_e = 1'b0;
        if (n > 0) begin
            ep = model(n - 1);
            irq_e = (ep.cnt == 0 && e.cnt != 0) || ((e.pers & ~ep.pers) != 0);
        end
        chk("model event_count", 64'(bus.event_count_o), 64'(e.cnt));
        chk("model sticky",      64'(bus.sticky_o),      64'(e.st));
        chk("model first_valid", 64'(bus.first_valid_o), 64'(e.fv));
        if (e.fv) chk("model first_idx", 64'(bus.first_idx_o), 64'(e.fidx));
        chk("model persistent",  64'(bus.persistent_o),  64'(e.pers));
        chk("model clear_ack",   64'(bus.clear_ack_o),   64'(e.ack));
        chk("model irq",         64'(bus.irq_o),         64'(irq_e));
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_clear();
        bus.clear_req_i = 1'b1; tick();
        bus.clear_req_i = 1'b0; tick();
    endtask

    logic [N-1:0] mm;
    int           req_left;

    initial begin
        bus.mismatch_i  = '0;
        bus.clear_req_i = 1'b0;
        #1;
        chk("reset count", 64'(bus.event_count_o), 64'd0);
        chk("reset ack",   64'(bus.clear_ack_o),   64'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // Single pulses on input 5 then input 2.
        bus.mismatch_i = 8'h20; tick();
        bus.mismatch_i = 8'h00; tick();
        chk("pulse5 count", 64'(bus.event_count_o), 64'd1);
        chk("pulse5 irq",   64'(bus.irq_o),         64'd1);
        chk("pulse5 fidx",  64'(bus.first_idx_o),   64'd5);
        chk("pulse5 fv",    64'(bus.first_valid_o), 64'd1);
        tick();
        chk("pulse5 irq drop", 64'(bus.irq_o), 64'd0);
        tick();
        bus.mismatch_i = 8'h04; tick();
        bus.mismatch_i = 8'h00; tick();
        chk("pulse2 count",  64'(bus.event_count_o), 64'd2);
        chk("pulse2 sticky", 64'(bus.sticky_o),      64'h24);
        chk("pulse2 fidx",   64'(bus.first_idx_o),   64'd5);
        chk("pulse2 irq",    64'(bus.irq_o),         64'd0);

        // All inputs pulsed three times against a 4-bit counter.
        do_clear();
        bus.mismatch_i = 8'hFF; tick();
        bus.mismatch_i = 8'h00; tick();
        chk("all count 8", 64'(bus.event_count_o), 64'd8);
        chk("all fidx",    64'(bus.first_idx_o),   64'd0);
        tick();
        bus.mismatch_i = 8'hFF; tick();
        bus.mismatch_i = 8'h00; tick();
        chk("all count sat", 64'(bus.event_count_o), 64'd15);
        tick();
        bus.mismatch_i = 8'hFF; tick();
        bus.mismatch_i = 8'h00; tick();
        chk("all count hold", 64'(bus.event_count_o), 64'd15);

        // Persistence: 15 cycles is not enough, 16 is.
        do_clear();
        bus.mismatch_i = 8'h08; repeat (15) tick();
        bus.mismatch_i = 8'h00; repeat (3) tick();
        chk("persist 15", 64'(bus.persistent_o), 64'd0);
        bus.mismatch_i = 8'h08; repeat (16) tick();
        chk("persist pre", 64'(bus.persistent_o), 64'd0);
        bus.mismatch_i = 8'h00; tick();
        chk("persist 16",  64'(bus.persistent_o), 64'h08);
        chk("persist irq", 64'(bus.irq_o),        64'd1);
        tick();
        chk("persist irq drop", 64'(bus.irq_o), 64'd0);

        // Clear while input 1 stays asserted.
        bus.mismatch_i = 8'h02; repeat (3) tick();
        bus.clear_req_i = 1'b1; tick();
        chk("clr count",  64'(bus.event_count_o), 64'd0);
        chk("clr sticky", 64'(bus.sticky_o),      64'd0);
        chk("clr pers",   64'(bus.persistent_o),  64'd0);
        chk("clr ack",    64'(bus.clear_ack_o),   64'd1);
        tick();
        chk("clr resticky", 64'(bus.sticky_o),      64'h02);
        chk("clr norecnt",  64'(bus.event_count_o), 64'd0);
        repeat (2) tick();
        bus.clear_req_i = 1'b0; tick();
        chk("clr ack drop", 64'(bus.clear_ack_o),   64'd0);
        chk("clr cnt hold", 64'(bus.event_count_o), 64'd0);
        bus.mismatch_i = 8'h00; repeat (2) tick();

        // Rise coinciding with the clearing edge is dropped.
        bus.mismatch_i = 8'h40; tick();
        bus.mismatch_i = 8'h00; bus.clear_req_i = 1'b1; tick();
        bus.clear_req_i = 1'b0; tick();
        chk("coinc count", 64'(bus.event_count_o), 64'd0);
        chk("coinc fv",    64'(bus.first_valid_o), 64'd0);

        // Asynchronous reset while in ACK with nonzero stats.
        bus.clear_req_i = 1'b1; tick();
        bus.mismatch_i = 8'h01; tick();
        bus.mismatch_i = 8'h00; tick();
        chk("ack stats count", 64'(bus.event_count_o), 64'd1);
        chk("ack stats ack",   64'(bus.clear_ack_o),   64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async count",  64'(bus.event_count_o), 64'd0);
        chk("async sticky", 64'(bus.sticky_o),      64'd0);
        chk("async ack",    64'(bus.clear_ack_o),   64'd0);
        chk("async fv",     64'(bus.first_valid_o), 64'd0);
        tick();
        bus.clear_req_i = 1'b0;
        rst_n = 1'b1;
        repeat (2) tick();

        // Randomized phase with sparse toggles, random clears and one reset.
        mm = '0;
        req_left = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            tick();
            if (cyc == 701) rst_n = 1'b1;
            mm = mm ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            if ($urandom_range(0, 15) == 0) mm = '0;
            if (req_left > 0) req_left--;
            else if ($urandom_range(0, 39) == 0) req_left = $urandom_range(1, 4);
            bus.mismatch_i  = mm;
            bus.clear_req_i = (req_left > 0);
            if (cyc == 700) #2 rst_n = 1'b0;
        end
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
